// File: rtl/lap_recall.sv
// Lap recall: fetches stored BCD lap times from the shared lap RAM and presents
// them one at a time to the display mux, with manual step, auto-scroll and exit.
module lap_recall #(
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 24,
   parameter int RD_LAT  = 1,
   parameter int AUTO_MS = 2000
) (
   input  logic              clk_50Mhz,
   input  logic              rst,
   input  logic              tick_1khz,
   input  logic              key_recall,
   input  logic              key_next,
   input  logic              key_exit,
   input  logic [ADDR_W:0]   lap_count,
   input  logic              bus_gnt,
   input  logic [DATA_W-1:0] ram_q,
   output logic              bus_req,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wren,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_sel,
   output logic [ADDR_W-1:0] lap_index,
   output logic              empty_pulse
);

   localparam int DW_W  = (AUTO_MS > 0) ? $clog2(AUTO_MS + 1) : 1;
   localparam int LAT_W = 2;
   localparam logic [ADDR_W:0] COUNT_ONE = 1;

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_ADDR, S_WAIT, S_CAPTURE, S_SHOW
   } state_t;

   state_t            state;
   logic [2:0]        sync_recall, sync_next, sync_exit;
   logic              recall_p, next_p, exit_p;
   logic [ADDR_W-1:0] index;
   logic [DW_W-1:0]   dwell;
   logic [LAT_W-1:0]  lat_cnt;
   logic              count_zero, last_idx, idx_oob, dwell_done;

   assign ram_wren = 1'b0;

   // bits [1:0] are the synchronizer, bit [2] the previous value for edge detect
   always_ff @(posedge clk_50Mhz or negedge rst) begin
      if (!rst) begin
         sync_recall <= '0;
         sync_next   <= '0;
         sync_exit   <= '0;
      end else begin
         sync_recall <= {sync_recall[1:0], key_recall};
         sync_next   <= {sync_next[1:0], key_next};
         sync_exit   <= {sync_exit[1:0], key_exit};
      end
   end

   assign recall_p = sync_recall[1] & ~sync_recall[2];
   assign next_p   = sync_next[1] & ~sync_next[2];
   assign exit_p   = sync_exit[1] & ~sync_exit[2];

   assign count_zero = (lap_count == '0);
   assign last_idx   = ({1'b0, index} == lap_count - COUNT_ONE);
   assign idx_oob    = ({1'b0, index} >= lap_count);
   assign dwell_done = (AUTO_MS > 0) && (dwell == DW_W'(AUTO_MS));

   always_ff @(posedge clk_50Mhz or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         index       <= '0;
         dwell       <= '0;
         lat_cnt     <= '0;
         bus_req     <= 1'b0;
         ram_addr    <= '0;
         disp_data   <= '0;
         disp_sel    <= 1'b0;
         lap_index   <= '0;
         empty_pulse <= 1'b0;
      end else begin
         empty_pulse <= 1'b0;

         // dwell only accumulates while a lap is on show; any other state clears it
         if (state != S_SHOW)
            dwell <= '0;
         else if (tick_1khz && !dwell_done)
            dwell <= dwell + DW_W'(1);

         if (state != S_IDLE && (exit_p || count_zero)) begin
            state    <= S_IDLE;
            disp_sel <= 1'b0;
            bus_req  <= 1'b0;
         end else if (state != S_IDLE && recall_p) begin
            index   <= '0;
            state   <= S_REQ;
            bus_req <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  if (recall_p) begin
                     if (count_zero) begin
                        empty_pulse <= 1'b1;
                     end else begin
                        index   <= '0;
                        state   <= S_REQ;
                        bus_req <= 1'b1;
                     end
                  end
               end
               S_REQ: begin
                  if (bus_gnt) begin
                     ram_addr <= index;
                     state    <= S_ADDR;
                  end
               end
               S_ADDR: begin
                  if (!bus_gnt) begin
                     state <= S_REQ;
                  end else begin
                     lat_cnt <= LAT_W'(RD_LAT - 1);
                     state   <= S_WAIT;
                  end
               end
               // ram_q is sampled on the WAIT exit edge so the shown value
               // changes RD_LAT+2 cycles after grant; CAPTURE is the hold cycle
               S_WAIT: begin
                  if (!bus_gnt) begin
                     state <= S_REQ;
                  end else if (lat_cnt == '0) begin
                     disp_data <= ram_q;
                     lap_index <= index;
                     disp_sel  <= 1'b1;
                     state     <= S_CAPTURE;
                  end else begin
                     lat_cnt <= lat_cnt - LAT_W'(1);
                  end
               end
               S_CAPTURE: begin
                  bus_req <= 1'b0;
                  state   <= S_SHOW;
               end
               S_SHOW: begin
                  if (idx_oob) begin
                     index   <= '0;
                     state   <= S_REQ;
                     bus_req <= 1'b1;
                  end else if (next_p || dwell_done) begin
                     index   <= last_idx ? '0 : index + ADDR_W'(1);
                     state   <= S_REQ;
                     bus_req <= 1'b1;
                  end
               end
               default: begin
                  state   <= S_IDLE;
                  bus_req <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
